mem_responder: RTL

- Memory-side responder that services quadword load, store, load-locked and store-conditional requests from the pipeline's memory stage.
- Requests and responses use valid/ready handshakes, with a configurable response latency.
- Owns the byte-addressed big-endian data store and the single LL/SC reservation.
- Returns SC status in the same {63'b0, flag} format the memory stage already writes back.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_responder_byte_store.sv | 43 ++++
 rtl/mem_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_pkg                                                          |
// | Purpose  : Shared types and helpers for the memory responder:              |
// |            FSM state encoding, operation encoding, quadword size and a     |
// |            helper that extracts the quadword index of a byte address.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LD  = 2'd0,
    OP_ST  = 2'd1,
    OP_LDL = 2'd2,
    OP_STC = 2'd3
  } op_t;

  localparam int QW_BYTES = 8;

  // Quadword index of a byte address inside a 2^addr_bits byte store.
  // Bits above the store width are discarded before the index is formed.
  function automatic logic [63:0] qw_index(input logic [63:0] addr, input int addr_bits);
    logic [63:0] mask;
    mask = (64'd1 << addr_bits) - 64'd1;
    return (addr & mask) >> 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_byte_store.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : byte_store                                                       |
// | Purpose  : 2^ADDR_BITS x 8 byte array holding big-endian quadwords.        |
// |            Combinational 8-byte read, synchronous 8-byte write. Byte       |
// |            indices wrap modulo the store depth.                            |
// | Ports    : clk   - clock                                                   |
// |            we    - write enable (8 bytes at addr..addr+7)                  |
// |            addr  - byte address of the quadword's MSB                      |
// |            wdata - quadword to write, MSB goes to addr                     |
// |            rdata - quadword read from addr..addr+7, MSB from addr          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module byte_store
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [63:0]          wdata,
  output logic [63:0]          rdata
);

  // Contents are intentionally never reset.
  logic [7:0] mem [2**ADDR_BITS];

  // Lane i holds byte addr+i; the address add wraps naturally at ADDR_BITS.
  for (genvar i = 0; i < QW_BYTES; i++) begin : g_lane
    assign rdata[8*(QW_BYTES-1-i) +: 8] = mem[addr + ADDR_BITS'(i)];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < QW_BYTES; i++) begin
        mem[addr + ADDR_BITS'(i)] <= wdata[8*(QW_BYTES-1-i) +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_responder                                                    |
// | Purpose  : Memory-side responder for quadword load, store, load-locked     |
// |            and store-conditional requests. Owns the byte store and the    |
// |            single LL/SC reservation; responds after LATENCY wait cycles.   |
// | Ports    : clk, reset            - clock, synchronous active-high reset    |
// |            req_valid/req_ready   - request handshake                       |
// |            req_write/ldl/stc     - op select (stc > write > load)          |
// |            req_addr, req_wdata   - byte address, store data                |
// |            resp_valid/resp_ready - response handshake                      |
// |            resp_data             - load data, store echo or SC status      |
// |            resp_stc_ok           - SC success flag                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_ldl,
  input  logic        req_stc,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_stc_ok
);

  localparam int QW_BITS = ADDR_BITS - 3;

  state_t               state;
  logic [3:0]           cnt;
  logic                 lock_valid;
  logic [QW_BITS-1:0]   lock_qw;

  logic [ADDR_BITS-1:0] addr;
  logic [63:0]          qw_full;
  logic [QW_BITS-1:0]   req_qw;
  logic [63:0]          rdata;
  logic                 accept;
  logic                 lock_hit;
  logic                 mem_we;
  op_t                  op;
  logic                 unused_bits;

  assign addr     = req_addr[ADDR_BITS-1:0];
  assign qw_full  = qw_index(req_addr, ADDR_BITS);
  // Unaligned accesses are matched on their own base quadword only.
  assign req_qw   = qw_full[QW_BITS-1:0];
  assign accept   = req_valid && req_ready && (state == IDLE);
  assign lock_hit = lock_valid && (lock_qw == req_qw);

  assign unused_bits = ^{req_addr[63:ADDR_BITS], qw_full[63:QW_BITS]};

  always_comb begin
    op = OP_LD;
    if (req_stc)        op = OP_STC;
    else if (req_write) op = OP_ST;
    else if (req_ldl)   op = OP_LDL;
  end

  // A failed SC leaves memory untouched.
  assign mem_we = accept && ((op == OP_ST) || ((op == OP_STC) && lock_hit));

  byte_store #(
    .ADDR_BITS (ADDR_BITS)
  ) u_store (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr),
    .wdata (req_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= 64'd0;
      resp_stc_ok <= 1'b0;
      lock_valid  <= 1'b0;
      lock_qw     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready   <= 1'b0;
            resp_stc_ok <= 1'b0;
            unique case (op)
              OP_LD: begin
                resp_data <= rdata;
              end
              OP_LDL: begin
                resp_data  <= rdata;
                lock_valid <= 1'b1;
                lock_qw    <= req_qw;
              end
              OP_ST: begin
                resp_data <= req_wdata;
                if (lock_hit) lock_valid <= 1'b0;
              end
              OP_STC: begin
                resp_data   <= {63'd0, lock_hit};
                resp_stc_ok <= lock_hit;
                lock_valid  <= 1'b0;
              end
              default: resp_data <= rdata;
            endcase
            cnt   <= 4'(LATENCY);
            state <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          // resp_valid rises on the first edge spent in RESP, so it appears
          // LATENCY+1 edges after the accept edge.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
